// File: rtl/aes_pkg.sv
// Shared constants for the AES-128 key schedule: word sizes, round limits,
// FSM encodings, the round-constant table and the byte S-box.
package aes_pkg;

  localparam int WORD_W     = 32;
  localparam int NK         = 4;
  localparam int KEY_W      = WORD_W * NK;
  localparam int AES_ROUNDS = 10;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // FSM encodings (plain constants so older tools and checkers can bind to them)
  typedef logic [1:0] ks_state_t;
  localparam ks_state_t ST_IDLE   = 2'd0;
  localparam ks_state_t ST_LOAD   = 2'd1;
  localparam ks_state_t ST_EXPAND = 2'd2;
  localparam ks_state_t ST_READY  = 2'd3;

  // Round constant for round r (1..10); index 0 and anything above 10 give 0.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Forward AES S-box, indexed by input byte.
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sbox_word.sv
// Combinational SubWord: four independent byte S-box lookups on a 32-bit
// word. Also usable four-wide for the datapath SubBytes.
module aes_sbox_word
  import aes_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  // Byte-wise substitution; byte lanes never interact.
  always_comb begin
    word_out = '0;
    for (int i = 0; i < 4; i++) begin
      word_out[8*i +: 8] = SBOX[word_in[8*i +: 8]];
    end
  end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128 key schedule. Loads the cipher key one word per cycle,
// then on each round request from the controller derives the next round key
// one word per cycle (4 cycles) and presents it with rk_valid.
//
// Handshake: rk_valid high means round_key corresponds to round_no and will
// not change while round_no stays put; busy is high only while a round key
// is being derived. ks_load is a one-word-per-cycle strobe with no backpressure.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int NK     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ks_load,
  input  logic [WORD_W-1:0]      key_word,
  input  logic [3:0]             round_no,
  output logic [WORD_W*NK-1:0]   round_key,
  output logic                   rk_valid,
  output logic                   busy,
  output logic                   seq_err,
  output logic [1:0]             fsm_state
);

  localparam int KW = WORD_W * NK;

  ks_state_t          state;
  logic [KW-1:0]      key0;
  logic [3:0]         cur_round;
  logic [2:0]         load_cnt;
  logic [1:0]         step;
  // New words of the round being derived, oldest in the top slot; the low
  // word is always the most recently produced word w(k-1)'.
  logic [3*WORD_W-1:0] exp_words;

  logic [3:0]         next_round;
  logic [WORD_W-1:0]  w3_rot;
  logic [WORD_W-1:0]  w3_sub;
  logic [WORD_W-1:0]  cur_word;
  logic [WORD_W-1:0]  new_word;

  assign next_round = cur_round + 4'd1;
  assign fsm_state  = state;

  // RotWord of the last word of the current round key feeds the S-box.
  assign w3_rot = {round_key[WORD_W-9:0], round_key[WORD_W-1:WORD_W-8]};

  aes_sbox_word u_sbox (
    .word_in  (w3_rot),
    .word_out (w3_sub)
  );

  // Pick the current-round word for this step and form its successor.
  always_comb begin
    cur_word = '0;
    new_word = '0;
    case (step)
      2'd0:    cur_word = round_key[KW-1          -: WORD_W];
      2'd1:    cur_word = round_key[KW-1-WORD_W   -: WORD_W];
      2'd2:    cur_word = round_key[KW-1-2*WORD_W -: WORD_W];
      default: cur_word = round_key[WORD_W-1:0];
    endcase
    if (step == 2'd0) begin
      new_word = cur_word ^ w3_sub ^ {rcon(next_round), {(WORD_W-8){1'b0}}};
    end else begin
      new_word = cur_word ^ exp_words[WORD_W-1:0];
    end
  end

  // Control FSM and key registers; ks_load overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      round_key <= '0;
      key0      <= '0;
      cur_round <= '0;
      load_cnt  <= '0;
      step      <= '0;
      exp_words <= '0;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      seq_err   <= 1'b0;
    end else if (ks_load) begin
      // Sliding window: the last four words shifted in form the key.
      round_key <= {round_key[KW-WORD_W-1:0], key_word};
      if (state != ST_LOAD) begin
        load_cnt <= 3'd1;
      end else if (load_cnt != 3'd4) begin
        load_cnt <= load_cnt + 3'd1;
      end
      cur_round <= '0;
      busy      <= 1'b0;
      rk_valid  <= 1'b0;
      step      <= '0;
      state     <= ST_LOAD;
    end else begin
      case (state)
        ST_LOAD: begin
          load_cnt <= '0;
          if (load_cnt == 3'd4) begin
            key0     <= round_key;
            rk_valid <= 1'b1;
            state    <= ST_READY;
          end else begin
            rk_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_READY: begin
          if (round_no == cur_round) begin
            rk_valid <= 1'b1;
          end else if (round_no == next_round && cur_round < LAST_ROUND) begin
            rk_valid <= 1'b0;
            busy     <= 1'b1;
            step     <= '0;
            state    <= ST_EXPAND;
          end else if (round_no == 4'd0) begin
            // Rewind to the cipher key in a single cycle.
            round_key <= key0;
            cur_round <= '0;
            rk_valid  <= 1'b1;
          end else begin
            seq_err  <= 1'b1;
            rk_valid <= 1'b0;
          end
        end
        ST_EXPAND: begin
          if (step == 2'd3) begin
            round_key <= {exp_words, new_word};
            cur_round <= next_round;
            busy      <= 1'b0;
            rk_valid  <= 1'b1;
            step      <= '0;
            state     <= ST_READY;
          end else begin
            exp_words <= {exp_words[2*WORD_W-1:0], new_word};
            step      <= step + 2'd1;
          end
        end
        default: begin
          rk_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Self-checking bench for aes_key_sched using the FIPS-197 AES-128 example
// key schedule as the reference.
module tb_aes_key_sched;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         ks_load;
  logic [31:0]  key_word;
  logic [3:0]   round_no;
  logic [127:0] round_key;
  logic         rk_valid;
  logic         busy;
  logic         seq_err;
  logic [1:0]   fsm_state;

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_q[$];
  logic [31:0]  word_q[$];

  localparam logic [127:0] RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  aes_key_sched #(.WORD_W(32), .NK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ks_load   (ks_load),
    .key_word  (key_word),
    .round_no  (round_no),
    .round_key (round_key),
    .rk_valid  (rk_valid),
    .busy      (busy),
    .seq_err   (seq_err),
    .fsm_state (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance one clock and settle past the edge before sampling/driving.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Shift in n words: from key k (rnd=0) or random (rnd=1). Words go to word_q.
  task automatic drive_words(input int n, input logic [127:0] k, input logic rnd);
    for (int i = 0; i < n; i++) begin
      key_word = rnd ? $urandom() : k[127-32*(i%4) -: 32];
      word_q.push_back(key_word);
      ks_load = 1'b1;
      step_clk();
    end
    ks_load  = 1'b0;
    key_word = '0;
  endtask

  // Load a full key and check it through the copy cycle.
  task automatic load_full_key(input logic [127:0] k);
    logic [127:0] exp;
    exp_q.push_back(k);
    drive_words(4, k, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (round_key !== exp) begin
      failures++;
      $display("FAIL load_key: round_key=%h expected=%h", round_key, exp);
    end
    step_clk();
    checks++;
    if (rk_valid !== 1'b1 || fsm_state !== ST_READY) begin
      failures++;
      $display("FAIL load_valid: rk_valid=%b state=%0d expected 1/%0d", rk_valid, fsm_state, ST_READY);
    end
  endtask

  // Request round r and wait (bounded) for the new key.
  task automatic request_round(input int r);
    int cyc;
    int busy_cnt;
    logic [127:0] exp;
    exp_q.push_back(RK[r]);
    round_no = r[3:0];
    cyc = 0;
    busy_cnt = 0;
    do begin
      step_clk();
      cyc++;
      if (busy === 1'b1) busy_cnt++;
    end while (rk_valid !== 1'b1 && cyc < 20);
    exp = exp_q.pop_front();
    checks++;
    if (rk_valid !== 1'b1) begin
      failures++;
      $display("FAIL round%0d_timeout: rk_valid=%b after %0d cycles, expected 1", r, rk_valid, cyc);
    end
    checks++;
    if (round_key !== exp) begin
      failures++;
      $display("FAIL round%0d_key: round_key=%h expected=%h", r, round_key, exp);
    end
    checks++;
    if (cyc != 5 || busy_cnt != 4) begin
      failures++;
      $display("FAIL round%0d_latency: cycles=%0d busy=%0d expected 5/4", r, cyc, busy_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ks_load = 1'b0; key_word = '0; round_no = '0;
    #1;
    checks++;
    if (round_key !== '0 || rk_valid !== 1'b0 || busy !== 1'b0 || seq_err !== 1'b0 || fsm_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset: key=%h v=%b b=%b e=%b st=%0d expected all 0", round_key, rk_valid, busy, seq_err, fsm_state);
    end
    step_clk();
    rst = 1'b0;
    step_clk();
  endtask

  task automatic test_load();
    load_full_key(RK[0]);
  endtask

  task automatic test_expand();
    request_round(1);
  endtask

  task automatic test_all_rounds();
    for (int r = 2; r <= 10; r++) request_round(r);
    checks++;
    if (seq_err !== 1'b0) begin
      failures++;
      $display("FAIL all_rounds_seq_err: seq_err=%b expected 0", seq_err);
    end
  endtask

  task automatic test_restore();
    round_no = 4'd0;
    step_clk();
    checks++;
    if (round_key !== RK[0] || rk_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL restore: key=%h v=%b b=%b expected %h/1/0", round_key, rk_valid, busy, RK[0]);
    end
    step_clk();
    checks++;
    if (rk_valid !== 1'b1 || round_key !== RK[0]) begin
      failures++;
      $display("FAIL restore_hold: key=%h v=%b expected %h/1", round_key, rk_valid, RK[0]);
    end
  endtask

  task automatic test_reset_mid_expand();
    round_no = 4'd1;
    step_clk();
    step_clk();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_expand_busy: busy=%b expected 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (round_key !== '0 || rk_valid !== 1'b0 || busy !== 1'b0 || seq_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: key=%h v=%b b=%b e=%b expected all 0", round_key, rk_valid, busy, seq_err);
    end
    round_no = 4'd0;
    step_clk();
    rst = 1'b0;
    step_clk();
  endtask

  task automatic test_illegal_jump();
    load_full_key(RK[0]);
    round_no = 4'd3;
    step_clk();
    checks++;
    if (seq_err !== 1'b1 || rk_valid !== 1'b0 || round_key !== RK[0]) begin
      failures++;
      $display("FAIL illegal_jump: e=%b v=%b key=%h expected 1/0/%h", seq_err, rk_valid, round_key, RK[0]);
    end
    round_no = 4'd0;
    step_clk();
    checks++;
    if (rk_valid !== 1'b1 || seq_err !== 1'b1) begin
      failures++;
      $display("FAIL jump_recover: v=%b e=%b expected 1/1", rk_valid, seq_err);
    end
    request_round(1);
    round_no = 4'd12;
    step_clk();
    checks++;
    if (rk_valid !== 1'b0 || round_key !== RK[1]) begin
      failures++;
      $display("FAIL out_of_range: v=%b key=%h expected 0/%h", rk_valid, round_key, RK[1]);
    end
  endtask

  task automatic test_partial_load();
    rst = 1'b1;
    round_no = 4'd0;
    step_clk();
    rst = 1'b0;
    drive_words(2, RK[0], 1'b0);
    step_clk();
    checks++;
    if (rk_valid !== 1'b0 || fsm_state !== ST_IDLE) begin
      failures++;
      $display("FAIL partial_load: v=%b st=%0d expected 0/%0d", rk_valid, fsm_state, ST_IDLE);
    end
    round_no = 4'd1;
    step_clk();
    step_clk();
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_ignores: b=%b v=%b expected 0/0", busy, rk_valid);
    end
    round_no = 4'd0;
  endtask

  task automatic test_sliding_window();
    logic [127:0] exp;
    word_q.delete();
    drive_words(6, '0, 1'b1);
    exp_q.push_back({word_q[2], word_q[3], word_q[4], word_q[5]});
    exp = exp_q.pop_front();
    checks++;
    if (round_key !== exp) begin
      failures++;
      $display("FAIL sliding_window: round_key=%h expected=%h", round_key, exp);
    end
    step_clk();
    checks++;
    if (rk_valid !== 1'b1 || round_key !== exp) begin
      failures++;
      $display("FAIL sliding_ready: v=%b key=%h expected 1/%h", rk_valid, round_key, exp);
    end
  endtask

  task automatic test_back_to_back();
    load_full_key(RK[0]);
    round_no = 4'd1;
    step_clk();
    step_clk();
    round_no = 4'd0;
    key_word = RK[0][127:96];
    ks_load  = 1'b1;
    step_clk();
    checks++;
    if (busy !== 1'b0 || fsm_state !== ST_LOAD) begin
      failures++;
      $display("FAIL load_aborts: b=%b st=%0d expected 0/%0d", busy, fsm_state, ST_LOAD);
    end
    ks_load = 1'b0;
    load_full_key(RK[0]);
    request_round(1);
    request_round(2);
  endtask

  initial begin
    test_reset();
    test_load();
    test_expand();
    test_all_rounds();
    test_restore();
    test_reset_mid_expand();
    test_illegal_jump();
    test_partial_load();
    test_sliding_window();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_key_sched.md
Name: aes_key_sched

Overview:
- Iterative AES-128 key-schedule stage, directly downstream of the AES round controller.
- Consumes the controller's key-select strobe and round number.
- Loads the 128-bit cipher key as four 32-bit words, then expands one round key per round on demand, one word per cycle.
- Presents the current round key to the AES datapath for AddRoundKey.

Parameters:
- WORD_W, 32, width of each loaded key word (fixed at 32 for AES-128; other values unsupported).
- NK, 4, number of key words per round key.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- ks_load  input  1  key-select strobe from controller; high = shift in one key word this cycle.
- key_word  input  32  key word, most-significant word (w0) first.
- round_no  input  4  requested round number from controller, 0..10.
- round_key  output  128  current round key {w0,w1,w2,w3}, w0 in bits [127:96].
- rk_valid  output  1  round_key matches round_no and is stable.
- busy  output  1  expansion in progress.
- seq_err  output  1  sticky; illegal round_no jump seen.

Behaviour:
- Reset (async, immediate): round_key=0, key0 copy=0, cur_round=0, load_cnt=0, step=0, rk_valid=0, busy=0, seq_err=0, state=IDLE.
- States: IDLE, LOAD, EXPAND, READY.
- Load rule, ks_load=1, any state, highest priority:
  - shift key_word into round_key (left shift by 32, new word in [31:0]);
  - load_cnt saturates at 4; cur_round<=0; busy<=0; any expansion in progress is aborted; state=LOAD.
- LOAD with ks_load=0:
  - if load_cnt==4: copy round_key into key0, rk_valid<=1, state=READY;
  - else: partial load, rk_valid=0, load_cnt<=0, state=IDLE.
- After a full load, the first cycle with ks_load=0 is the copy cycle; rk_valid rises the next cycle.
- Words beyond four act as a sliding window: the last four words win.
- READY, each cycle compare round_no with cur_round:
  - round_no==cur_round: hold.
  - round_no==cur_round+1 and cur_round<10: rk_valid<=0, busy<=1, step<=0, state=EXPAND.
  - round_no==0 and cur_round!=0: restore round_key<=key0, cur_round<=0 in one cycle; rk_valid stays 1 on the following cycle.
  - any other mismatch, including round_no>10: seq_err<=1 (sticky until rst); round_key unchanged; rk_valid<=0 until round_no returns to cur_round.
- EXPAND, one word per cycle, step 0..3, using r = cur_round+1:
  - step0: w0' = w0 ^ SubWord(RotWord(w3)) ^ {RCON[r],24'h0}.
  - step k>0: wk' = wk ^ w(k-1)', with w(k-1)' taken from a temporary register.
  - After step3: commit all four words, cur_round<=r, busy<=0, rk_valid<=1, state=READY.
  - Latency: request seen at cycle T; rk_valid=1 at T+5. This fits the controller's 5-cycle round spacing.
- round_no changing during EXPAND is ignored until READY, then re-evaluated.
- IDLE: outputs hold; round_no changes are ignored; rk_valid=0.
- Arithmetic is pure XOR; no carries. RCON indexed 1..10; index 0 unused.

Decomposition:
- Package aes_pkg:
  - RCON table: 01,02,04,08,10,20,40,80,1B,36;
  - state enum;
  - AES_ROUNDS=10;
  - word-width constants.
- One sub-module, aes_sbox_word: combinational SubWord of 32 bits (four byte S-box lookups). The same block is reusable for the datapath SubBytes.

Test Plan:
- Load 2b7e1516,28aed2a6,abf71588,09cf4f3c over 4 cycles, then drop ks_load -> round_key=2b7e151628aed2a6abf7158809cf4f3c; rk_valid=1 two cycles after ks_load falls.
- From that key, round_no 0->1 -> busy for 4 cycles; round_key=a0fafe1788542cb123a339392a6c7605; rk_valid=1 at T+5.
- Step round_no 1..10 at 5-cycle spacing -> final round_key=d014f9a8c9ee2589e13f0cc8b6630ca6; seq_err=0.
- After round 10, round_no=0 -> round_key returns to 2b7e1516... next cycle, with no busy.
- Exercise rst and illegal jumps:
  - assert rst mid-EXPAND -> all outputs 0 immediately;
  - after reload at round 0, set round_no=3 -> seq_err=1, round_key unchanged.
- Exercise load edge cases:
  - ks_load for only 2 words -> rk_valid=0, state IDLE;
  - ks_load for 6 words -> round_key holds words 3..6.
